// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
interface muldiv_unit_if;
  logic        START;
  logic [2:0]  OP;
  logic [31:0] SRC_A;
  logic [31:0] SRC_B;
  logic        BUSY;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output START, OP, SRC_A, SRC_B,
    input  BUSY, HI, LO
  );

  modport slave (
    input  START, OP, SRC_A, SRC_B,
    output BUSY, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit with HI/LO registers. The result is computed at acceptance and
// held pending until the configured latency expires, so HI/LO timing matches a real iterative unit.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // The acceptance cycle is the first busy cycle, so RUN lasts one cycle less than the latency.
  localparam logic [3:0] MultRun = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivRun  = 4'(DIV_CYCLES - 1);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  logic        r_skip;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_long;
  logic        w_is_div;
  logic        w_div_zero;
  logic [3:0]  w_run_len;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_den_u;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q_m;
  logic [31:0] w_r_m;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [63:0] w_result;

  assign w_is_long  = ~bus.OP[2];
  assign w_is_div   = bus.OP[1];
  assign w_div_zero = (bus.SRC_B == 32'd0);
  assign w_run_len  = w_is_div ? DivRun : MultRun;

  // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
  assign w_prod_s = {{32{bus.SRC_A[31]}}, bus.SRC_A} * {{32{bus.SRC_B[31]}}, bus.SRC_B};
  assign w_prod_u = {32'd0, bus.SRC_A} * {32'd0, bus.SRC_B};

  // Divisor forced to 1 on divide-by-zero; that result is discarded via r_skip.
  assign w_den_u = w_div_zero ? 32'd1 : bus.SRC_B;
  assign w_q_u   = bus.SRC_A / w_den_u;
  assign w_r_u   = bus.SRC_A % w_den_u;

  // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow trap.
  assign w_mag_a = bus.SRC_A[31] ? -bus.SRC_A : bus.SRC_A;
  assign w_mag_b = w_div_zero ? 32'd1 : (bus.SRC_B[31] ? -bus.SRC_B : bus.SRC_B);
  assign w_q_m   = w_mag_a / w_mag_b;
  assign w_r_m   = w_mag_a % w_mag_b;
  assign w_q_s   = (bus.SRC_A[31] ^ bus.SRC_B[31]) ? -w_q_m : w_q_m;
  assign w_r_s   = bus.SRC_A[31] ? -w_r_m : w_r_m;

  always_comb begin
    w_result = 64'd0;
    unique case (bus.OP[1:0])
      2'd0:    w_result = w_prod_s;
      2'd1:    w_result = w_prod_u;
      2'd2:    w_result = {w_r_s, w_q_s};
      default: w_result = {w_r_u, w_q_u};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_pend  <= 64'd0;
      r_skip  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.START) begin
            if (w_is_long) begin
              r_pend <= w_result;
              r_skip <= w_is_div & w_div_zero;
              if (w_run_len == 4'd0) begin
                if (!(w_is_div & w_div_zero)) begin
                  r_hi <= w_result[63:32];
                  r_lo <= w_result[31:0];
                end
              end else begin
                r_cnt   <= w_run_len;
                r_state <= StRun;
              end
            end else if (bus.OP == 3'd4) begin
              r_hi <= bus.SRC_A;
            end else if (bus.OP == 3'd5) begin
              r_lo <= bus.SRC_A;
            end
          end
        end
        StRun: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_skip) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.BUSY = (bus.START & w_is_long) | (r_state == StRun);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
